// File: rtl/palette_arb_pkg.sv
// palette_arb_pkg: shared defaults, types and helpers for the palette lookup arbiter.
package palette_arb_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int IDX_W_DEF = 5;
    localparam int RGB_W_DEF = 12;
    localparam int MAX_NREQ  = 8;

    typedef logic [RGB_W_DEF-1:0] rgb_t;
    typedef logic [IDX_W_DEF-1:0] idx_t;

    function automatic logic [2:0] oh2idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < MAX_NREQ; i++) r = r | (oh[i] ? 3'(i) : 3'd0);
        return r;
    endfunction
endpackage

// File: rtl/palette_lookup_arbiter_rr_pick2.sv
// rr_pick2: finds the first two valid requesters in round-robin order starting at ptr_i.
module rr_pick2
    import palette_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         valid_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt0_o,
    output logic [NREQ-1:0]         gnt1_o,
    output logic                    found0_o,
    output logic                    found1_o
);
    logic [NREQ-1:0] upper, rest;

    function automatic logic [NREQ-1:0] lowest(input logic [NREQ-1:0] v);
        return v & (~v + NREQ'(1));
    endfunction

    // Positions at or above the pointer win first; falling back to the whole vector is the wrap.
    always_comb begin
        upper    = ~((NREQ'(1) << ptr_i) - NREQ'(1));
        gnt0_o   = lowest(|(valid_i & upper) ? (valid_i & upper) : valid_i);
        rest     = valid_i & ~gnt0_o;
        gnt1_o   = lowest(|(rest & upper) ? (rest & upper) : rest);
        found0_o = |gnt0_o;
        found1_o = |gnt1_o;
    end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: shares two external palette read ports among NREQ requesters,
// round-robin, two grants per cycle, registering each requester's looked-up colour.
module palette_lookup_arbiter
    import palette_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int RGB_W = RGB_W_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][IDX_W-1:0] req_index,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ-1:0][RGB_W-1:0] rsp_rgb,
    output logic [IDX_W-1:0]           pal_index0,
    output logic [IDX_W-1:0]           pal_index1,
    input  logic [RGB_W-1:0]           pal_rgb0,
    input  logic [RGB_W-1:0]           pal_rgb1,
    output logic [15:0]                stall_cnt
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]              ptr_q, ptr_d, sel0, sel1;
    logic [NREQ-1:0]            gnt0, gnt1, rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0][RGB_W-1:0] rsp_rgb_q, rsp_rgb_d;
    logic [15:0]                stall_q, stall_d;
    logic                       found0, found1;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] s);
        return (s == PW'(NREQ - 1)) ? '0 : s + PW'(1);
    endfunction

    rr_pick2 #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1),
        .found0_o(found0),
        .found1_o(found1)
    );

    always_comb begin
        sel0        = PW'(oh2idx(MAX_NREQ'(gnt0)));
        sel1        = PW'(oh2idx(MAX_NREQ'(gnt1)));
        req_ready   = Reset ? '0 : (gnt0 | gnt1);
        pal_index0  = (Reset || !found0) ? '0 : req_index[sel0];
        pal_index1  = (Reset || !found1) ? '0 : req_index[sel1];
        ptr_d       = found1 ? next_ptr(sel1) : found0 ? next_ptr(sel0) : ptr_q;
        rsp_valid_d = req_ready;
        for (int i = 0; i < NREQ; i++)
            rsp_rgb_d[i] = gnt0[i] ? pal_rgb0 : gnt1[i] ? pal_rgb1 : rsp_rgb_q[i];
        stall_d     = ($countones(req_valid) > 2 && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rgb_q   <= '0;
            stall_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rgb_q   <= rsp_rgb_d;
            stall_q     <= stall_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rgb   = rsp_rgb_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb_palette_lookup_arbiter: randomized scoreboard bench against a round-robin reference model.
module tb_palette_lookup_arbiter;
    import palette_arb_pkg::*;
    localparam int N = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    idx_t [N-1:0]     req_index = '0;
    logic [N-1:0]     req_ready, rsp_valid;
    rgb_t [N-1:0]     rsp_rgb;
    idx_t             pal_index0, pal_index1;
    rgb_t             pal_rgb0, pal_rgb1;
    logic [15:0]      stall_cnt;
    int               checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    function automatic rgb_t pal(input idx_t a);
        case (a)
            5'd3:    return 12'hE63;
            5'd4:    return 12'h000;
            5'd6:    return 12'h0BF;
            5'd9:    return 12'hF00;
            default: return 12'({a, a[3:0]}) ^ 12'h5A5;
        endcase
    endfunction

    assign pal_rgb0 = pal(pal_index0);
    assign pal_rgb1 = pal(pal_index1);

    palette_lookup_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rgb   (rsp_rgb),
        .pal_index0(pal_index0),
        .pal_index1(pal_index1),
        .pal_rgb0  (pal_rgb0),
        .pal_rgb1  (pal_rgb1),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: walk requesters in order from p, first two valid ones are granted.
    int           p = 0, n;
    int           g[2];
    int           waitc[N];
    logic [15:0]  m_stall = '0;
    logic [N-1:0] eg, last_hs = '0;
    rgb_t         exq[N][$];

    always @(negedge Clk) begin
        eg = '0;
        n = 0;
        g[0] = 0;
        g[1] = 0;
        for (int k = 0; k < N; k++)
            if (!Reset && n < 2 && req_valid[(p + k) % N]) begin
                g[n] = (p + k) % N;
                eg[g[n]] = 1'b1;
                n++;
            end
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("pal_index0", 32'(pal_index0), n > 0 ? 32'(req_index[g[0]]) : 32'd0);
        chk("pal_index1", 32'(pal_index1), n > 1 ? 32'(req_index[g[1]]) : 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        last_hs = req_valid & req_ready;
        for (int k = 0; k < n; k++) exq[g[k]].push_back(pal(req_index[g[k]]));
        for (int i = 0; i < N; i++) begin
            waitc[i] = (!Reset && req_valid[i] && !eg[i]) ? waitc[i] + 1 : 0;
            checks++;
            if (waitc[i] > 1) begin
                errors++;
                $display("FAIL wait_bound req%0d at %0t: waited %0d cycles, limit 1", i, $time, waitc[i]);
            end
        end
        if (Reset) begin
            p = 0;
            m_stall = '0;
        end else begin
            if (n > 0) p = (g[n-1] + 1) % N;
            if ($countones(req_valid) > 2 && m_stall != 16'hFFFF) m_stall++;
        end
    end

    rgb_t last_rgb[N];
    logic rst_pend = 1'b1;

    always @(posedge Clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (rst_pend) begin
                last_rgb[i] = '0;
                exq[i].delete();
            end
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(exq[i].size() != 0));
            if (exq[i].size() != 0) last_rgb[i] = exq[i].pop_front();
            chk($sformatf("rsp_rgb[%0d]", i), 32'(rsp_rgb[i]), 32'(last_rgb[i]));
        end
        rst_pend = Reset;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req_valid = '0;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) waitc[i] = 0;
        do_reset();

        req_valid = 4'b0001;
        req_index[0] = 5'd9;
        @(negedge Clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_pal0", 32'(pal_index0), 32'd9);
        step();
        req_valid = '0;
        chk("single_rspv", 32'(rsp_valid), 32'h1);
        chk("single_rgb", 32'(rsp_rgb[0]), 32'hF00);

        do_reset();
        req_index = {5'd9, 5'd6, 5'd4, 5'd3};
        req_valid = 4'b1111;
        @(negedge Clk);
        chk("rr_first", 32'(req_ready), 32'h3);
        step();
        @(negedge Clk);
        chk("rr_second", 32'(req_ready), 32'hC);
        step();
        @(negedge Clk);
        chk("rr_third", 32'(req_ready), 32'h3);
        repeat (3) step();

        req_valid = 4'b0110;
        req_index[1] = 5'd6;
        req_index[2] = 5'd6;
        @(negedge Clk);
        chk("same_pal0", 32'(pal_index0), 32'd6);
        chk("same_pal1", 32'(pal_index1), 32'd6);
        step();
        req_valid = '0;
        chk("same_rspv", 32'(rsp_valid), 32'h6);
        chk("same_rgb1", 32'(rsp_rgb[1]), 32'h0BF);
        chk("same_rgb2", 32'(rsp_rgb[2]), 32'h0BF);

        req_valid = 4'b1111;
        repeat (3) step();
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        step();
        step();
        Reset = 1'b0;
        chk("rst_rspv", 32'(rsp_valid), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        @(negedge Clk);
        chk("rst_first_grant", 32'(req_ready), 32'h3);
        repeat (3) step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_hs[i]) req_valid[i] = ($urandom_range(0, 3) != 0);
                req_index[i] = 5'($urandom_range(0, 31));
            end
            step();
        end

        do_reset();
        req_valid = 4'b0111;
        repeat (65540) step();
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        req_valid = '0;
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
